sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 19, SRAM halfword address width.
REQ-002 Parameter DATA_W, default 16, SRAM data width.
REQ-003 clk  input  1  system clock (50 MHz); all state on rising edge.
REQ-004 resetn  input  1  reset; asynchronous assertion, active-low.
REQ-005 p0_valid / p1_valid  input  1  request from port 0 (CPU path) / port 1 (loader/DMA path).
REQ-006 p0_ready / p1_ready  output  1  one-cycle completion pulse to the owning port.
REQ-007 p0_we / p1_we  input  1  1 = write, 0 = read.
REQ-008 p0_addr / p1_addr  input  ADDR_W  halfword address.
REQ-009 p0_wdata / p1_wdata  input  DATA_W  write data.
REQ-010 p0_rdata / p1_rdata  output  DATA_W  read data; valid only with the matching pN_ready.
REQ-011 p0_lock / p1_lock  input  1  hold grant across back-to-back transfers.
REQ-012 sram_valid  output  1  request to the SRAM driver.
REQ-013 sram_ready  input  1  one-cycle completion pulse from the SRAM driver.
REQ-014 sram_we, sram_addr, sram_wdata  output  1/ADDR_W/DATA_W  latched command to the driver.
REQ-015 sram_rdata  input  DATA_W  driver read data.
REQ-016 busy  output  1  transfer in flight; owner  output  1  current or last grantee.

Function
REQ-017 The arbiter SHALL use states IDLE, XFER and LOCKED, with a 1-bit owner register.
REQ-018 In IDLE, a valid request sampled at edge N SHALL move the arbiter to XFER and latch the winner's we/addr/wdata into the sram_* registers at edge N, so sram_valid is high from cycle N+1.
REQ-019 If only one port is valid, that port SHALL win. If both are valid, the winner SHALL follow REQ-031/REQ-032.
REQ-020 In XFER, sram_valid and the latched command SHALL stay stable until sram_ready, even if the owner drops its valid.
REQ-021 pN_ready SHALL equal sram_ready AND (owner==N) AND state==XFER, combinationally, adding no latency.
REQ-022 pN_rdata SHALL be driven from sram_rdata, with no register stage.
REQ-023 On sram_ready in XFER: if pN_lock of the owner is high, the next state SHALL be LOCKED; otherwise it SHALL be IDLE. sram_valid SHALL deassert at that edge in both cases.
REQ-024 In LOCKED, only the owner's request SHALL be accepted (treated as in REQ-018). The other port SHALL wait.
REQ-025 In LOCKED, the arbiter SHALL return to IDLE when the owner's lock is low and its valid is low.
REQ-026 The non-owner's valid SHALL never produce a ready pulse. A sram_ready seen in IDLE or LOCKED SHALL be ignored.
REQ-027 A new grant SHALL never occur in the same cycle as sram_ready. Minimum spacing between transfers is one idle cycle on the driver.
REQ-028 busy SHALL be high exactly while state==XFER.

Reset
REQ-029 On resetn low, the arbiter SHALL immediately go to IDLE and clear owner to 0. sram_valid, sram_we, sram_addr and sram_wdata SHALL be 0; busy and pN_ready SHALL be 0.
REQ-030 A reset in mid-transfer SHALL abandon the transfer with no ready pulse. Release SHALL restart arbitration from IDLE.

Configuration
REQ-031 With SRAM_ARB_RR_EN defined, contention SHALL be resolved round-robin: the port that is not owner wins, and owner updates on each grant.
REQ-032 Without SRAM_ARB_RR_EN, contention SHALL be resolved by fixed priority, with port 0 always winning.

Structure
REQ-033 State encodings (IDLE/XFER/LOCKED) and the default ADDR_W/DATA_W constants SHALL live in a shared package, sram_arb_pkg.
REQ-034 Winner selection SHALL be one sub-module, sram_arb_pick: a combinational priority/round-robin picker. All other logic SHALL be in the top module.

Verification
REQ-035 p0 read at addr 0x00010, driver returns 0xBEEF after 5 cycles -> sram_valid is high at N+1, p0_ready pulses once with p0_rdata=0xBEEF, and p1_ready stays 0.
REQ-036 p0 and p1 both valid at the same edge, fixed-priority build -> p0 is served first and p1 next, with one idle cycle between. RR build with owner=0 -> p1 is served first.
REQ-037 p1 holds p1_lock for 4 write transfers while p0 is valid throughout -> all 4 p1 writes complete before p0 is granted, and p0 is granted within 2 cycles of lock release.
REQ-038 Owner drops valid, and changes addr to 0x7FFFF, in the cycle after grant -> sram_addr keeps the latched value until sram_ready.
REQ-039 resetn is pulsed low in mid-XFER -> sram_valid is 0 asynchronously, no pN_ready pulse occurs, and the next request is granted normally.
REQ-040 sram_ready is injected while in IDLE -> no pN_ready pulse and no state change.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sram_arb_pkg
// Shared definitions for the two-port SRAM arbiter: arbiter state encoding and
// the default SRAM halfword address / data widths.
//
// Contents:
//   ADDR_W_DEF   default halfword address width (19)
//   DATA_W_DEF   default SRAM data width (16)
//   arb_state_t  IDLE / XFER / LOCKED arbiter states
// -----------------------------------------------------------------------------
package sram_arb_pkg;

    localparam int ADDR_W_DEF = 19;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_XFER   = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_t;

endpackage : sram_arb_pkg

// File: rtl/sram_arb_pick.sv
// -----------------------------------------------------------------------------
// sram_arb_pick
// Combinational winner picker for the two-port SRAM arbiter.
//
// Ports:
//   req         in   [1:0] request vector, bit N = port N valid
//   last_owner  in   1     current/last grantee (used for round-robin)
//   grant       out  1     at least one port is requesting
//   winner      out  1     index of the winning port (meaningful with grant)
//
// Build option:
//   SRAM_ARB_RR_EN  defined   -> contention goes to the port that is not
//                                last_owner (round-robin)
//                   undefined -> contention always goes to port 0
// -----------------------------------------------------------------------------
module sram_arb_pick (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       grant,
    output logic       winner
);

    always_comb begin
        grant  = |req;
        winner = 1'b0;
        if (req == 2'b10) begin
            winner = 1'b1;
        end
`ifdef SRAM_ARB_RR_EN
        else if (req == 2'b11) begin
            winner = ~last_owner;
        end
`endif
    end

`ifndef SRAM_ARB_RR_EN
    // Fixed priority never looks at the previous grantee.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

endmodule : sram_arb_pick

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
// Arbitrates two request ports (port 0 = CPU path, port 1 = loader/DMA path)
// onto a single SRAM driver. One transfer is in flight at a time; the winning
// command is latched and held stable until the driver's completion pulse. A
// port holding its lock line keeps the grant across back-to-back transfers.
//
// Parameters:
//   ADDR_W  halfword address width (default 19)
//   DATA_W  data width (default 16)
//
// Ports:
//   clk, resetn                     clock, async active-low reset
//   pN_valid / pN_we / pN_addr /
//   pN_wdata / pN_lock              port N request, direction, address, write
//                                   data, grant-hold request
//   pN_ready / pN_rdata             port N completion pulse and read data
//   sram_valid / sram_we /
//   sram_addr / sram_wdata          latched command to the SRAM driver
//   sram_ready / sram_rdata         driver completion pulse and read data
//   busy                            transfer in flight
//   owner                           current or last grantee
//
// Build option:
//   SRAM_ARB_RR_EN  round-robin contention resolution (default: port 0 wins)
// -----------------------------------------------------------------------------
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p0_lock,

    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    input  logic              p1_lock,

    output logic              sram_valid,
    input  logic              sram_ready,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,

    output logic              busy,
    output logic              owner
);

    arb_state_t state;
    arb_state_t state_next;

    logic              pick_grant;
    logic              pick_winner;
    logic              owner_valid;
    logic              owner_lock;
    logic              grant;
    logic              grant_port;
    logic              grant_we;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;

    sram_arb_pick u_pick (
        .req        ({p1_valid, p0_valid}),
        .last_owner (owner),
        .grant      (pick_grant),
        .winner     (pick_winner)
    );

    assign owner_valid = owner ? p1_valid : p0_valid;
    assign owner_lock  = owner ? p1_lock  : p0_lock;

    // Grants only happen from IDLE or LOCKED, so a grant can never coincide
    // with a completion pulse: the driver always sees at least one idle cycle.
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_port = owner;
        case (state)
            ST_IDLE: begin
                if (pick_grant) begin
                    grant      = 1'b1;
                    grant_port = pick_winner;
                    state_next = ST_XFER;
                end
            end
            ST_XFER: begin
                if (sram_ready) begin
                    state_next = owner_lock ? ST_LOCKED : ST_IDLE;
                end
            end
            ST_LOCKED: begin
                // Only the lock holder may be granted; the other port waits.
                if (owner_valid) begin
                    grant      = 1'b1;
                    state_next = ST_XFER;
                end else if (!owner_lock) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign grant_we    = grant_port ? p1_we    : p0_we;
    assign grant_addr  = grant_port ? p1_addr  : p0_addr;
    assign grant_wdata = grant_port ? p1_wdata : p0_wdata;

    // The command is captured only at the grant edge, so later changes on the
    // port (including dropping valid) cannot disturb the transfer in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            owner      <= 1'b0;
            sram_valid <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
        end else begin
            state      <= state_next;
            sram_valid <= (state_next == ST_XFER);
            if (grant) begin
                owner      <= grant_port;
                sram_we    <= grant_we;
                sram_addr  <= grant_addr;
                sram_wdata <= grant_wdata;
            end
        end
    end

    assign busy     = (state == ST_XFER);
    assign p0_ready = sram_ready && (state == ST_XFER) && !owner;
    assign p1_ready = sram_ready && (state == ST_XFER) &&  owner;
    assign p0_rdata = sram_rdata;
    assign p1_rdata = sram_rdata;

endmodule : sram_arbiter

// File: tb/tb_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_arbiter
// Self-checking bench for sram_arbiter. A transaction-level reference model
// tracks which port holds the SRAM, whether a transfer is outstanding and
// whether the grant is reserved by a lock; a compare process checks every DUT
// output against it each cycle. Directed scenarios pin the model with literal
// expectations, then randomized traffic with a randomized-latency driver runs.
// Honours SRAM_ARB_RR_EN for the contention rule.
// -----------------------------------------------------------------------------
module tb_sram_arbiter;

    localparam int AW = 19;
    localparam int DW = 16;

`ifdef SRAM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          p0_valid = 1'b0, p0_we = 1'b0, p0_lock = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p1_valid = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;
    logic          sram_ready = 1'b0;
    logic [DW-1:0] sram_rdata = '0;
    logic          p0_ready, p1_ready, sram_valid, sram_we, busy, owner;
    logic [DW-1:0] p0_rdata, p1_rdata, sram_wdata;
    logic [AW-1:0] sram_addr;

    int total = 0;
    int bad   = 0;
    int rc0   = 0;
    int rc1   = 0;
    int c0, c1, got, drv_lat;
    logic          first;
    logic [AW-1:0] first_addr;

    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .p0_valid   (p0_valid),
        .p0_ready   (p0_ready),
        .p0_we      (p0_we),
        .p0_addr    (p0_addr),
        .p0_wdata   (p0_wdata),
        .p0_rdata   (p0_rdata),
        .p0_lock    (p0_lock),
        .p1_valid   (p1_valid),
        .p1_ready   (p1_ready),
        .p1_we      (p1_we),
        .p1_addr    (p1_addr),
        .p1_wdata   (p1_wdata),
        .p1_rdata   (p1_rdata),
        .p1_lock    (p1_lock),
        .sram_valid (sram_valid),
        .sram_ready (sram_ready),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .busy       (busy),
        .owner      (owner)
    );

    always #5 clk = ~clk;

    // Reference model: one outstanding transaction, its owner and command,
    // and whether the owner has reserved the next grant by locking.
    logic          m_out = 1'b0;
    logic          m_held = 1'b0;
    logic          m_owner = 1'b0;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;

    always @(posedge clk or negedge resetn) begin : model
        int         w;
        logic [1:0] v;
        logic [1:0] lk;
        if (!resetn) begin
            m_out   <= 1'b0;
            m_held  <= 1'b0;
            m_owner <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            v  = {p1_valid, p0_valid};
            lk = {p1_lock, p0_lock};
            w  = -1;
            if (m_out) begin
                if (sram_ready) begin
                    m_out  <= 1'b0;
                    m_held <= lk[m_owner];
                end
            end else if (m_held) begin
                if (v[m_owner]) w = m_owner ? 1 : 0;
                else if (!lk[m_owner]) m_held <= 1'b0;
            end else if (v == 2'b11) begin
                w = (RR_MODE && !m_owner) ? 1 : 0;
            end else if (v[0]) begin
                w = 0;
            end else if (v[1]) begin
                w = 1;
            end
            if (w >= 0) begin
                m_out   <= 1'b1;
                m_owner <= (w == 1);
                m_we    <= (w == 1) ? p1_we    : p0_we;
                m_addr  <= (w == 1) ? p1_addr  : p0_addr;
                m_wdata <= (w == 1) ? p1_wdata : p0_wdata;
            end
        end
    end

    always @(posedge clk) begin
        if (p0_ready) rc0 <= rc0 + 1;
        if (p1_ready) rc1 <= rc1 + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #2;
        checkOutput("m.sram_valid", 32'(sram_valid), 32'(m_out));
        checkOutput("m.busy",       32'(busy),       32'(m_out));
        checkOutput("m.owner",      32'(owner),      32'(m_owner));
        checkOutput("m.sram_we",    32'(sram_we),    32'(m_we));
        checkOutput("m.sram_addr",  32'(sram_addr),  32'(m_addr));
        checkOutput("m.sram_wdata", 32'(sram_wdata), 32'(m_wdata));
        checkOutput("m.p0_ready",   32'(p0_ready),   32'(sram_ready && m_out && !m_owner));
        checkOutput("m.p1_ready",   32'(p1_ready),   32'(sram_ready && m_out && m_owner));
        checkOutput("m.p0_rdata",   32'(p0_rdata),   32'(sram_rdata));
        checkOutput("m.p1_rdata",   32'(p1_rdata),   32'(sram_rdata));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic serve(input int lat, input logic [DW-1:0] rd);
        repeat (lat) @(negedge clk);
        sram_rdata = rd;
        sram_ready = 1'b1;
        @(negedge clk);
        sram_ready = 1'b0;
    endtask

    task automatic applyStimulus();
        if (!resetn) resetn = 1'b1;
        else if ($urandom_range(0, 399) == 0) resetn = 1'b0;
        p0_valid   = ($urandom_range(0, 1) == 1);
        p1_valid   = ($urandom_range(0, 1) == 1);
        p0_lock    = ($urandom_range(0, 3) == 0);
        p1_lock    = ($urandom_range(0, 3) == 0);
        p0_we      = 1'($urandom);
        p1_we      = 1'($urandom);
        p0_addr    = AW'($urandom);
        p1_addr    = AW'($urandom);
        p0_wdata   = DW'($urandom);
        p1_wdata   = DW'($urandom);
        sram_rdata = DW'($urandom);
        if (sram_ready) begin
            sram_ready = 1'b0;
        end else if (sram_valid) begin
            if (drv_lat == 0) begin
                sram_ready = 1'b1;
                drv_lat    = $urandom_range(0, 4);
            end else begin
                drv_lat--;
            end
        end else begin
            sram_ready = ($urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        drv_lat = 0;
        repeat (2) tick();
        #1;
        checkOutput("reset.sram_valid", 32'(sram_valid), 32'd0);
        checkOutput("reset.owner",      32'(owner),      32'd0);
        checkOutput("reset.busy",       32'(busy),       32'd0);
        tick();
        resetn = 1'b1;

        // Single port-0 read, driver answers 0xBEEF.
        tick();
        p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 19'h00010;
        tick();
        p0_valid = 1'b0;
        #1;
        checkOutput("read.sram_valid", 32'(sram_valid), 32'd1);
        checkOutput("read.sram_addr",  32'(sram_addr),  32'h10);
        checkOutput("read.busy",       32'(busy),       32'd1);
        c0 = rc0; c1 = rc1;
        repeat (4) tick();
        sram_rdata = 16'hBEEF; sram_ready = 1'b1;
        #1;
        checkOutput("read.p0_ready", 32'(p0_ready), 32'd1);
        checkOutput("read.p0_rdata", 32'(p0_rdata), 32'hBEEF);
        checkOutput("read.p1_ready", 32'(p1_ready), 32'd0);
        tick();
        sram_ready = 1'b0;
        #1;
        checkOutput("read.done_valid", 32'(sram_valid), 32'd0);
        checkOutput("read.p0_pulses",  32'(rc0 - c0), 32'd1);
        checkOutput("read.p1_pulses",  32'(rc1 - c1), 32'd0);

        // Contention at the same edge.
        first      = RR_MODE ? 1'b1 : 1'b0;
        first_addr = RR_MODE ? 19'h200 : 19'h100;
        tick();
        p0_valid = 1'b1; p0_addr = 19'h100; p0_we = 1'b0;
        p1_valid = 1'b1; p1_addr = 19'h200; p1_we = 1'b0;
        tick();
        #1;
        checkOutput("cont.first_owner", 32'(owner),     32'(first));
        checkOutput("cont.first_addr",  32'(sram_addr), 32'(first_addr));
        if (first) p1_valid = 1'b0;
        else       p0_valid = 1'b0;
        serve(1, 16'h1111);
        #1;
        checkOutput("cont.gap", 32'(sram_valid), 32'd0);
        tick();
        #1;
        checkOutput("cont.second_valid", 32'(sram_valid), 32'd1);
        checkOutput("cont.second_owner", 32'(owner),      32'(!first));
        p0_valid = 1'b0; p1_valid = 1'b0;
        serve(2, 16'h2222);

        // Port 1 locks for four writes while port 0 waits.
        p1_valid = 1'b1; p1_lock = 1'b1; p1_we = 1'b1;
        p1_addr = 19'h400; p1_wdata = 16'hA000;
        tick();
        #1;
        checkOutput("lock.owner0", 32'(owner),     32'd1);
        checkOutput("lock.addr0",  32'(sram_addr), 32'h400);
        p0_valid = 1'b1; p0_addr = 19'h300; p0_we = 1'b0;
        c0 = rc0; c1 = rc1;
        for (int i = 0; i < 4; i++) begin
            tick();
            sram_ready = 1'b1;
            if (i == 3) begin
                p1_lock = 1'b0; p1_valid = 1'b0;
            end
            tick();
            sram_ready = 1'b0;
            if (i < 3) begin
                p1_addr  = AW'(32'h401 + 32'(i));
                p1_wdata = DW'(32'hA001 + 32'(i));
                tick();
                #1;
                checkOutput("lock.owner", 32'(owner),     32'd1);
                checkOutput("lock.addr",  32'(sram_addr), 32'h401 + 32'(i));
            end
        end
        got = 0;
        for (int k = 0; k < 2; k++) begin
            tick();
            #1;
            if (got == 0 && sram_valid && owner == 1'b0) got = 1;
        end
        checkOutput("lock.p0_granted", 32'(got),       32'd1);
        checkOutput("lock.p0_addr",    32'(sram_addr), 32'h300);
        checkOutput("lock.p1_pulses",  32'(rc1 - c1),  32'd4);
        checkOutput("lock.p0_pulses",  32'(rc0 - c0),  32'd0);
        p0_valid = 1'b0;
        serve(1, 16'h3333);

        // Owner withdraws and scribbles on its address after the grant.
        tick();
        p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 19'h555; p0_wdata = 16'h1234;
        tick();
        p0_valid = 1'b0; p0_addr = 19'h7FFFF; p0_wdata = 16'h0000;
        for (int k = 0; k < 2; k++) begin
            tick();
            #1;
            checkOutput("hold.addr", 32'(sram_addr), 32'h555);
        end
        tick();
        sram_ready = 1'b1;
        #1;
        checkOutput("hold.addr_at_ready", 32'(sram_addr),  32'h555);
        checkOutput("hold.wdata",         32'(sram_wdata), 32'h1234);
        checkOutput("hold.we",            32'(sram_we),    32'd1);
        checkOutput("hold.p0_ready",      32'(p0_ready),   32'd1);
        tick();
        sram_ready = 1'b0;

        // Reset in the middle of a transfer.
        p1_valid = 1'b1; p1_addr = 19'h42; p1_we = 1'b0;
        tick();
        p1_valid = 1'b0;
        #1;
        checkOutput("rst.granted", 32'(owner), 32'd1);
        c0 = rc0; c1 = rc1;
        #3;
        resetn = 1'b0; sram_ready = 1'b1;
        #1;
        checkOutput("rst.sram_valid", 32'(sram_valid), 32'd0);
        checkOutput("rst.busy",       32'(busy),       32'd0);
        checkOutput("rst.p0_ready",   32'(p0_ready),   32'd0);
        checkOutput("rst.p1_ready",   32'(p1_ready),   32'd0);
        checkOutput("rst.sram_addr",  32'(sram_addr),  32'd0);
        tick();
        sram_ready = 1'b0; resetn = 1'b1;
        #1;
        checkOutput("rst.no_pulse", 32'(rc0 - c0 + rc1 - c1), 32'd0);
        p0_valid = 1'b1; p0_addr = 19'h77; p0_we = 1'b0;
        tick();
        p0_valid = 1'b0;
        #1;
        checkOutput("rst.regrant_valid", 32'(sram_valid), 32'd1);
        checkOutput("rst.regrant_addr",  32'(sram_addr),  32'h77);
        serve(1, 16'h4444);

        // Stray completion pulse while idle.
        tick();
        sram_ready = 1'b1;
        #1;
        checkOutput("stray.p0_ready", 32'(p0_ready), 32'd0);
        checkOutput("stray.p1_ready", 32'(p1_ready), 32'd0);
        tick();
        sram_ready = 1'b0;
        #1;
        checkOutput("stray.busy",  32'(busy),  32'd0);
        checkOutput("stray.owner", 32'(owner), 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            tick();
            applyStimulus();
        end
        tick();
        resetn = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sram_arbiter
